// File: rtl/map_pkg.sv
// map_pkg
// Shared definitions for the program-flow controller slice: default
// address width and return-stack depth, plus the sequencer FSM state
// encoding used by pc_sequencer.
package map_pkg;

  localparam int DEF_ADDR_W      = 8;
  localparam int DEF_STACK_DEPTH = 8;

  // BOOT is the single idle cycle after reset, FETCH drives requests,
  // HALT parks the sequencer until a resume strobe arrives.
  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    FETCH = 2'd1,
    HALT  = 2'd2
  } seq_state_t;

endpackage

// File: rtl/pc_sequencer_if.sv
// pc_sequencer_if
// Instruction-memory fetch bus between the program-flow controller and
// instruction memory.
//   oADDR     : fetch address (current PC), driven by the sequencer
//   oMEM_REQ  : fetch request, driven by the sequencer
//   iMEM_ACK  : memory accepted the current oADDR, driven by memory
// Modports: master = sequencer side, slave = memory side.
interface pc_sequencer_if
  import map_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W
) ();

  logic [ADDR_W-1:0] oADDR;
  logic              oMEM_REQ;
  logic              iMEM_ACK;

  modport master (
    output oADDR,
    output oMEM_REQ,
    input  iMEM_ACK
  );

  modport slave (
    input  oADDR,
    input  oMEM_REQ,
    output iMEM_ACK
  );

endinterface

// File: rtl/return_stack.sv
// return_stack
// LIFO holding return addresses for the program-flow controller.
//   clk, rst  : clock, synchronous active-high reset (clears occupancy only)
//   i_push    : write i_data on top (ignored when full)
//   i_pop     : discard top entry (ignored when empty)
//   i_data    : return address to push
//   o_top     : current top entry (valid when not empty)
//   o_count   : occupancy, 0..DEPTH
//   o_full    : occupancy equals DEPTH
//   o_empty   : occupancy is zero
// Push and pop are never requested together by the sequencer; if they
// were, push would win.
module return_stack
  import map_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DEPTH  = DEF_STACK_DEPTH,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_push,
  input  logic              i_pop,
  input  logic [ADDR_W-1:0] i_data,
  output logic [ADDR_W-1:0] o_top,
  output logic [CNT_W-1:0]  o_count,
  output logic              o_full,
  output logic              o_empty
);

  logic [ADDR_W-1:0] r_mem [DEPTH];
  logic [CNT_W-1:0]  r_count;
  logic [PTR_W-1:0]  w_topIdx;
  logic              w_doPush;
  logic              w_doPop;

  assign o_full   = (r_count == CNT_W'(DEPTH));
  assign o_empty  = (r_count == '0);
  assign w_doPush = i_push & ~o_full;
  assign w_doPop  = i_pop & ~o_empty & ~w_doPush;

  // The count is one past the top entry; the low bits of count address
  // the next free slot, which is always in range when not full.
  assign w_topIdx = PTR_W'(r_count - CNT_W'(1));
  assign o_top    = r_mem[w_topIdx];
  assign o_count  = r_count;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= '0;
    end else if (w_doPush) begin
      r_count <= r_count + CNT_W'(1);
    end else if (w_doPop) begin
      r_count <= r_count - CNT_W'(1);
    end
  end

  // Entries carry no reset; stale contents are never observable because
  // reads are only meaningful below the occupancy count.
  always_ff @(posedge clk) begin
    if (w_doPush) begin
      r_mem[r_count[PTR_W-1:0]] <= i_data;
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer
// Program-flow controller: owns the PC and the hardware return stack,
// issues instruction fetches with a req/ack handshake and applies the
// next-PC decision once per accepted fetch.
//   CLK, RST  : clock, synchronous active-high reset
//   mem       : fetch bus (master modport): oADDR, oMEM_REQ, iMEM_ACK
//   iSTALL    : re-fetch the same address
//   iJMP      : jump to iTGT
//   iCALL     : push return address, jump to iTGT
//   iRET      : pop return address into PC
//   iHALT     : enter HALT
//   iRESUME   : leave HALT, refetch the held PC
//   iTGT      : jump/call target
//   oSP       : return-stack occupancy, 0..STACK_DEPTH
//   oSTK_ERR  : sticky stack under/overflow flag, cleared only by RST
//   oHALTED   : high while in HALT
// Build option: define STACK_OVERFLOW_TRAP_EN to send a call on a full
// stack to TRAP_VEC instead of treating it as a plain jump to iTGT.
module pc_sequencer
  import map_pkg::*;
#(
  parameter int                ADDR_W      = DEF_ADDR_W,
  parameter int                STACK_DEPTH = DEF_STACK_DEPTH,
  parameter logic [ADDR_W-1:0] RESET_VEC   = '0,
  parameter logic [ADDR_W-1:0] TRAP_VEC    = '1
) (
  input  logic                         CLK,
  input  logic                         RST,
  pc_sequencer_if.master               mem,
  input  logic                         iSTALL,
  input  logic                         iJMP,
  input  logic                         iCALL,
  input  logic                         iRET,
  input  logic                         iHALT,
  input  logic                         iRESUME,
  input  logic [ADDR_W-1:0]            iTGT,
  output logic [$clog2(STACK_DEPTH):0] oSP,
  output logic                         oSTK_ERR,
  output logic                         oHALTED
);

`ifdef STACK_OVERFLOW_TRAP_EN
  localparam bit TRAP_EN = 1'b1;
`else
  localparam bit TRAP_EN = 1'b0;
`endif

  seq_state_t        r_state;
  logic [ADDR_W-1:0] r_pc;
  logic              r_memReq;
  logic              r_halted;
  logic              r_stkErr;

  logic              w_ack;
  logic              w_ret;
  logic              w_call;
  logic              w_push;
  logic              w_pop;
  logic [ADDR_W-1:0] w_retAddr;
  logic [ADDR_W-1:0] w_ovfTgt;
  logic [ADDR_W-1:0] w_top;
  logic              w_full;
  logic              w_empty;

  // Strobes only matter in the ack cycle, and only the highest-priority
  // one counts; stack side effects are derived from the same priority.
  assign w_ack     = (r_state == FETCH) & mem.iMEM_ACK;
  assign w_ret     = w_ack & ~iHALT & ~iSTALL & iRET;
  assign w_call    = w_ack & ~iHALT & ~iSTALL & ~iRET & iCALL;
  assign w_push    = w_call & ~w_full;
  assign w_pop     = w_ret & ~w_empty;
  assign w_retAddr = r_pc + ADDR_W'(1);
  assign w_ovfTgt  = TRAP_EN ? TRAP_VEC : iTGT;

  return_stack #(
    .ADDR_W (ADDR_W),
    .DEPTH  (STACK_DEPTH)
  ) u_stack (
    .clk     (CLK),
    .rst     (RST),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_data  (w_retAddr),
    .o_top   (w_top),
    .o_count (oSP),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  // Sequencer FSM and PC. oMEM_REQ and oHALTED are registered alongside
  // the state so they change on the same edge as the state they reflect.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state  <= BOOT;
      r_pc     <= RESET_VEC;
      r_memReq <= 1'b0;
      r_halted <= 1'b0;
      r_stkErr <= 1'b0;
    end else begin
      case (r_state)
        BOOT: begin
          r_state  <= FETCH;
          r_memReq <= 1'b1;
        end
        FETCH: begin
          if (mem.iMEM_ACK) begin
            if (iHALT) begin
              r_state  <= HALT;
              r_memReq <= 1'b0;
              r_halted <= 1'b1;
            end else if (iSTALL) begin
              r_pc <= r_pc;
            end else if (iRET) begin
              if (w_empty) begin
                r_stkErr <= 1'b1;
                r_pc     <= w_retAddr;
              end else begin
                r_pc <= w_top;
              end
            end else if (iCALL) begin
              if (w_full) begin
                r_stkErr <= 1'b1;
                r_pc     <= w_ovfTgt;
              end else begin
                r_pc <= iTGT;
              end
            end else if (iJMP) begin
              r_pc <= iTGT;
            end else begin
              r_pc <= w_retAddr;
            end
          end
        end
        HALT: begin
          if (iRESUME) begin
            r_state  <= FETCH;
            r_memReq <= 1'b1;
            r_halted <= 1'b0;
          end
        end
        default: begin
          r_state  <= BOOT;
          r_memReq <= 1'b0;
          r_halted <= 1'b0;
        end
      endcase
    end
  end

  assign mem.oADDR    = r_pc;
  assign mem.oMEM_REQ = r_memReq;
  assign oSTK_ERR     = r_stkErr;
  assign oHALTED      = r_halted;

endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer
// Self-checking bench for pc_sequencer (ADDR_W=8, STACK_DEPTH=8).
// A queue-based reference model tracks PC, return stack, error flag and
// halted/boot status; every cycle the DUT outputs are compared to it.
// Directed sequences add literal expectations, then a randomized run
// exercises all strobes, random acks and occasional resets.
module tb_pc_sequencer;

`ifdef STACK_OVERFLOW_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  logic       CLK = 1'b0;
  logic       RST;
  logic       iSTALL, iJMP, iCALL, iRET, iHALT, iRESUME;
  logic [7:0] iTGT;
  logic [3:0] oSP;
  logic       oSTK_ERR;
  logic       oHALTED;

  pc_sequencer_if #(.ADDR_W(8)) mem ();

  pc_sequencer dut (
    .CLK      (CLK),
    .RST      (RST),
    .mem      (mem),
    .iSTALL   (iSTALL),
    .iJMP     (iJMP),
    .iCALL    (iCALL),
    .iRET     (iRET),
    .iHALT    (iHALT),
    .iRESUME  (iRESUME),
    .iTGT     (iTGT),
    .oSP      (oSP),
    .oSTK_ERR (oSTK_ERR),
    .oHALTED  (oHALTED)
  );

  always #5 CLK = ~CLK;

  int total = 0;
  int bad   = 0;

  // Reference model state
  logic [7:0] mPc;
  logic [7:0] mStk[$];
  bit         mErr, mReq, mHalted, mBoot;

  task automatic cmp(input string name, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Advance the model by one rising edge using the inputs present at it.
  task automatic modelStep();
    logic [7:0] nxt;
    nxt = mPc + 8'd1;
    if (RST) begin
      mPc = 8'h00; mStk.delete(); mErr = 0; mReq = 0; mHalted = 0; mBoot = 1;
    end else if (mBoot) begin
      mBoot = 0; mReq = 1;
    end else if (mHalted) begin
      if (iRESUME) begin mHalted = 0; mReq = 1; end
    end else if (mem.iMEM_ACK) begin
      if (iHALT) begin
        mHalted = 1; mReq = 0;
      end else if (iSTALL) begin
        mPc = mPc;
      end else if (iRET) begin
        if (mStk.size() == 0) begin mErr = 1; mPc = nxt; end
        else mPc = mStk.pop_back();
      end else if (iCALL) begin
        if (mStk.size() == 8) begin mErr = 1; mPc = TRAP ? 8'hFF : iTGT; end
        else begin mStk.push_back(nxt); mPc = iTGT; end
      end else if (iJMP) begin
        mPc = iTGT;
      end else begin
        mPc = nxt;
      end
    end
  endtask

  task automatic checkOutput();
    cmp("oADDR", int'(mem.oADDR), int'(mPc));
    cmp("oMEM_REQ", int'(mem.oMEM_REQ), int'(mReq));
    cmp("oSP", int'(oSP), mStk.size());
    cmp("oSTK_ERR", int'(oSTK_ERR), int'(mErr));
    cmp("oHALTED", int'(oHALTED), int'(mHalted));
  endtask

  // Inputs are held across one rising edge, then outputs are sampled 1ns later.
  task automatic applyStimulus(input bit rst, input bit ack, input bit stall,
                               input bit jmp, input bit call, input bit ret,
                               input bit halt, input bit resume, input logic [7:0] tgt);
    RST = rst; mem.iMEM_ACK = ack; iSTALL = stall; iJMP = jmp; iCALL = call;
    iRET = ret; iHALT = halt; iRESUME = resume; iTGT = tgt;
    @(posedge CLK);
    modelStep();
    #1;
    checkOutput();
  endtask

  task automatic idle(input bit ack);
    applyStimulus(0, ack, 0, 0, 0, 0, 0, 0, 8'h00);
  endtask

  initial begin
    RST = 1; mem.iMEM_ACK = 0; iSTALL = 0; iJMP = 0; iCALL = 0; iRET = 0;
    iHALT = 0; iRESUME = 0; iTGT = 0;
    mPc = 0; mErr = 0; mReq = 0; mHalted = 0; mBoot = 1;
    #2;

    // Reset, then straight-line fetch with ack held high
    applyStimulus(1, 1, 0, 0, 0, 0, 0, 0, 8'h00);
    cmp("rst_addr", int'(mem.oADDR), 8'h00);
    cmp("rst_req", int'(mem.oMEM_REQ), 0);
    cmp("rst_sp", int'(oSP), 0);
    idle(1);
    cmp("boot_req", int'(mem.oMEM_REQ), 1);
    cmp("seq0", int'(mem.oADDR), 8'h00);
    idle(1); cmp("seq1", int'(mem.oADDR), 8'h01);
    idle(1); idle(1); cmp("seq3", int'(mem.oADDR), 8'h03);

    // Call / return round trip
    applyStimulus(0, 1, 0, 1, 0, 0, 0, 0, 8'h10);
    applyStimulus(0, 1, 0, 0, 1, 0, 0, 0, 8'h40);
    cmp("call_addr", int'(mem.oADDR), 8'h40);
    cmp("call_sp", int'(oSP), 1);
    idle(1); idle(1); idle(1);
    cmp("inc3", int'(mem.oADDR), 8'h43);
    applyStimulus(0, 1, 0, 0, 0, 1, 0, 0, 8'h00);
    cmp("ret_addr", int'(mem.oADDR), 8'h11);
    cmp("ret_sp", int'(oSP), 0);

    // Wraparound of increment and of the pushed return address
    applyStimulus(0, 1, 0, 1, 0, 0, 0, 0, 8'hFF);
    idle(1);
    cmp("wrap_inc", int'(mem.oADDR), 8'h00);
    applyStimulus(0, 1, 0, 1, 0, 0, 0, 0, 8'hFF);
    applyStimulus(0, 1, 0, 0, 1, 0, 0, 0, 8'h20);
    applyStimulus(0, 1, 0, 0, 0, 1, 0, 0, 8'h00);
    cmp("wrap_ret", int'(mem.oADDR), 8'h00);

    // Stall beats jump; halt beats call; halted ignores strobes
    applyStimulus(0, 1, 1, 1, 0, 0, 0, 0, 8'h30);
    cmp("stall_addr", int'(mem.oADDR), 8'h00);
    applyStimulus(0, 1, 0, 0, 1, 0, 1, 0, 8'h44);
    cmp("halt_flag", int'(oHALTED), 1);
    cmp("halt_req", int'(mem.oMEM_REQ), 0);
    cmp("halt_sp", int'(oSP), 0);
    applyStimulus(0, 1, 0, 1, 1, 1, 0, 0, 8'h77);
    applyStimulus(0, 1, 0, 0, 0, 0, 0, 1, 8'h00);
    cmp("resume_req", int'(mem.oMEM_REQ), 1);
    cmp("resume_addr", int'(mem.oADDR), 8'h00);

    // Nine nested calls on an eight-deep stack
    for (int i = 0; i < 9; i++) begin
      applyStimulus(0, 1, 0, 0, 1, 0, 0, 0, 8'h50 + 8'(i));
      if (i == 7) cmp("full_err0", int'(oSTK_ERR), 0);
    end
    cmp("ovf_sp", int'(oSP), 8);
    cmp("ovf_err", int'(oSTK_ERR), 1);
    cmp("ovf_addr", int'(mem.oADDR), TRAP ? 8'hFF : 8'h58);
    for (int i = 0; i < 5; i++) applyStimulus(0, 1, 0, 0, 0, 1, 0, 0, 8'h00);
    cmp("pop5_sp", int'(oSP), 3);

    // Reset in the middle of an outstanding request
    idle(0);
    cmp("pending_req", int'(mem.oMEM_REQ), 1);
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 8'h00);
    cmp("mid_rst_addr", int'(mem.oADDR), 8'h00);
    cmp("mid_rst_sp", int'(oSP), 0);
    cmp("mid_rst_err", int'(oSTK_ERR), 0);
    cmp("mid_rst_req", int'(mem.oMEM_REQ), 0);

    // Return on an empty stack
    idle(1);
    applyStimulus(0, 1, 0, 0, 0, 1, 0, 0, 8'h00);
    cmp("und_err", int'(oSTK_ERR), 1);
    cmp("und_addr", int'(mem.oADDR), 8'h01);

    // Randomized run against the model
    for (int n = 0; n < 3000; n++) begin
      applyStimulus($urandom_range(0, 199) == 0,
                    $urandom_range(0, 3) != 0,
                    $urandom_range(0, 9) == 0,
                    $urandom_range(0, 5) == 0,
                    $urandom_range(0, 4) == 0,
                    $urandom_range(0, 4) == 0,
                    $urandom_range(0, 24) == 0,
                    $urandom_range(0, 2) == 0,
                    8'($urandom));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
